match_round_controller: RTL and testbench
=========================================

// Module: match_round_controller
// PURPOSE
//  Sequences a two-player match around both player_next_state_calc instances.
//  Turns frame_clk into a one-cycle sys_clk frame strobe and runs the round flow: countdown, fight, clash, round end, match end.
//  Adjudicates raw hit detections from collision logic into per-player attack_connected flags, one outcome per frame.
//  Keeps round scores and freezes player inputs outside the FIGHT phase.
// PARAMETERS
//  COUNTDOWN_FRAMES  180   frames from round start to FIGHT
//  CLASH_FRAMES      30    frames held after a simultaneous hit before re-countdown
//  ROUND_END_FRAMES  120   frames the round result is held
//  ROUND_FRAMES      3600  round time limit in frames (ROUND_TIMER_EN only)
//  WINS_TO_MATCH     2     round wins that end the match
//  CNT_W             12    frame-counter width; must hold max(*_FRAMES)-1
//  SCORE_W           2     score width; must hold WINS_TO_MATCH
// PORTS
//  sys_clk              in   1        system clock; all flops clocked here
//  resetn               in   1        asynchronous active-low reset
//  frame_clk            in   1        frame-rate clock, asynchronous to sys_clk
//  start_btn            in   1        level; starts a match from IDLE or MATCH_END
//  p1_hit_raw           in   1        P1 hitbox overlaps P2 hurtbox this frame
//  p2_hit_raw           in   1        P2 hitbox overlaps P1 hurtbox this frame
//  frame_tick           out  1        1-cycle strobe per frame; enable for player calc
//  p1_attack_connected  out  1        adjudicated P1 hit; held through ROUND_END
//  p2_attack_connected  out  1        adjudicated P2 hit; held through ROUND_END
//  players_frozen       out  1        1 = player button inputs are ignored
//  round_phase          out  3        0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 CLASH, 4 ROUND_END, 5 MATCH_END
//  phase_count          out  CNT_W    frames remaining in the current timed phase
//  p1_score             out  SCORE_W  P1 round wins
//  p2_score             out  SCORE_W  P2 round wins
//  match_over           out  1        high in MATCH_END
//  match_winner         out  1        0 = P1, 1 = P2; valid while match_over
// BEHAVIOUR
//  Reset: phase IDLE; all outputs 0 except players_frozen=1; start_pending cleared.
//  Frame tick: frame_clk passes a 2-flop synchronizer and rising-edge detect.
//  - frame_tick rises 3 sys_clk edges after the frame_clk rising edge; it lasts exactly 1 cycle.
//  Phase transitions and counter updates happen only on frame_tick.
//  start_pending is set on any cycle with start_btn=1; it is consumed on the next tick.
//  IDLE/MATCH_END + tick + start_pending -> COUNTDOWN.
//  - On this transition: scores cleared, phase_count=COUNTDOWN_FRAMES-1, match_over=0.
//  COUNTDOWN: decrement per tick; tick at 0 -> FIGHT.
//  FIGHT: hit_raw inputs are sampled only on tick.
//  - p1 only: p1_attack_connected=1, p1_score+1, -> ROUND_END. p2 only is symmetric.
//  - Both: neither flag set, no score change, -> CLASH with CLASH_FRAMES-1.
//  - Neither: stay in FIGHT.
//  CLASH: count down; tick at 0 -> COUNTDOWN.
//  ROUND_END: count from ROUND_END_FRAMES-1; tick at 0 clears connected flags.
//  - Then -> MATCH_END if either score == WINS_TO_MATCH, else -> COUNTDOWN.
//  - MATCH_END sets match_over=1 and match_winner from the scoring player.
//  Scores saturate at WINS_TO_MATCH. The connected flags are never both 1.
//  players_frozen = (round_phase != FIGHT).
//  hit_raw is ignored outside FIGHT.
//  Reset asserted mid-phase forces IDLE immediately, asynchronously.
// CONFIGURATION
//  MATCH_ROUND_TIMER_EN defined:
//  - FIGHT loads phase_count=ROUND_FRAMES-1 and decrements per tick.
//  - Tick at 0 with no hit -> ROUND_END as a draw: no flags, no score.
//  - A hit on the same tick as expiry takes priority over the timeout.
//  MATCH_ROUND_TIMER_EN undefined:
//  - FIGHT holds phase_count=0; a round ends only on a hit or clash.
// STRUCTURE
//  params.vh: phase encodings (PH_IDLE..PH_MATCH_END) and the phase width constant.
//  - The player state encodings (WIN/LOSE) it already holds stay there.
//  Sub-module frame_tick_sync: 2-flop synchronizer, edge detect, frame_tick output.
//  Top level: phase FSM, shared down-counter, score registers, start latch.
// TESTING (bench overrides: COUNTDOWN=3, CLASH=2, ROUND_END=2, ROUND=5, WINS=2)
//  1. Reset; start_btn pulse; 4 ticks.
//     -> phases IDLE, COUNTDOWN(2,1,0), FIGHT; frozen=0 only in FIGHT.
//  2. FIGHT, p1_hit_raw=1 on one tick.
//     -> p1_attack_connected=1, p1_score=1, ROUND_END for 2 ticks, then COUNTDOWN, flags=0.
//  3. FIGHT, both hit_raw=1 on the same tick.
//     -> CLASH for 2 ticks, scores unchanged, connected flags stay 0.
//  4. P2 wins two rounds.
//     -> MATCH_END, match_over=1, match_winner=1, p2_score=2.
//     -> start pulse returns to COUNTDOWN with scores 0.
//  5. Timer on, 5 FIGHT ticks with no hit -> draw, ROUND_END, scores unchanged.
//     Same again with p1 hit on the expiry tick -> p1 scores.
//  6. resetn low mid-ROUND_END -> IDLE, all outputs 0 and frozen=1 without waiting for sys_clk.
//     frame_clk edge 1 cycle after reset release -> exactly one frame_tick.

Source files
------------

// File: rtl/match_round_controller_pkg.sv
// Shared encodings for the match/round sequencer: round phases and player result states.
package match_round_controller_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_FIGHT     = 3'd2,
    PH_CLASH     = 3'd3,
    PH_ROUND_END = 3'd4,
    PH_MATCH_END = 3'd5
  } phase_e;

  // Per-player result encodings consumed by the player state calculators.
  typedef enum logic [1:0] {
    PS_NONE = 2'd0,
    PS_WIN  = 2'd1,
    PS_LOSE = 2'd2
  } player_result_e;

endpackage

// File: rtl/match_round_controller_frame_tick_sync.sv
// Brings frame_clk into the sys_clk domain and emits a one-cycle strobe per rising edge.
// The strobe is registered, so it rises on the third sys_clk edge after frame_clk rises.
module match_round_controller_frame_tick_sync (
  input  logic sys_clk,
  input  logic resetn,
  input  logic frame_clk,
  output logic frame_tick
);

  // [0],[1] are the synchronizer pair; [2] holds the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], frame_clk};
      frame_tick <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/match_round_controller.sv
// Two-player round/match sequencer: frame strobe, phase FSM, shared frame down-counter, scores.
// Optional round time limit is enabled by defining MATCH_ROUND_TIMER_EN.
module match_round_controller
  import match_round_controller_pkg::*;
#(
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CLASH_FRAMES     = 30,
  parameter int ROUND_END_FRAMES = 120,
  parameter int ROUND_FRAMES     = 3600,
  parameter int WINS_TO_MATCH    = 2,
  parameter int CNT_W            = 12,
  parameter int SCORE_W          = 2
) (
  input  logic               sys_clk,
  input  logic               resetn,
  input  logic               frame_clk,
  input  logic               start_btn,
  input  logic               p1_hit_raw,
  input  logic               p2_hit_raw,
  output logic               frame_tick,
  output logic               p1_attack_connected,
  output logic               p2_attack_connected,
  output logic               players_frozen,
  output logic [PHASE_W-1:0] round_phase,
  output logic [CNT_W-1:0]   phase_count,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               match_over,
  output logic               match_winner
);

`ifdef MATCH_ROUND_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]   CD_LOAD    = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CLASH_LOAD = CNT_W'(CLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   RE_LOAD    = CNT_W'(ROUND_END_FRAMES - 1);
  localparam logic [CNT_W-1:0]   FIGHT_LOAD = TIMER_EN ? CNT_W'(ROUND_FRAMES - 1) : '0;
  localparam logic [SCORE_W-1:0] WIN_SCORE  = SCORE_W'(WINS_TO_MATCH);

  match_round_controller_frame_tick_sync u_frame_tick_sync (
    .sys_clk    (sys_clk),
    .resetn     (resetn),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               f1_q, f1_d, f2_q, f2_d;
  logic               over_q, over_d, winner_q, winner_d;
  logic               pend_q, pend_d;
  logic               cnt_zero;

  assign cnt_dec  = cnt_q - CNT_W'(1);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    over_d   = over_q;
    winner_d = winner_q;
    pend_d   = pend_q | start_btn;

    if (frame_tick) begin
      // A press landing on the tick cycle itself is kept for the following tick.
      pend_d = start_btn;
      case (phase_q)
        PH_IDLE, PH_MATCH_END: begin
          if (pend_q) begin
            phase_d = PH_COUNTDOWN;
            cnt_d   = CD_LOAD;
            s1_d    = '0;
            s2_d    = '0;
            over_d  = 1'b0;
          end
        end
        PH_COUNTDOWN: begin
          if (cnt_zero) begin
            phase_d = PH_FIGHT;
            cnt_d   = FIGHT_LOAD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        PH_FIGHT: begin
          if (p1_hit_raw && p2_hit_raw) begin
            phase_d = PH_CLASH;
            cnt_d   = CLASH_LOAD;
          end else if (p1_hit_raw) begin
            phase_d = PH_ROUND_END;
            cnt_d   = RE_LOAD;
            f1_d    = 1'b1;
            s1_d    = (s1_q >= WIN_SCORE) ? s1_q : s1_q + SCORE_W'(1);
          end else if (p2_hit_raw) begin
            phase_d = PH_ROUND_END;
            cnt_d   = RE_LOAD;
            f2_d    = 1'b1;
            s2_d    = (s2_q >= WIN_SCORE) ? s2_q : s2_q + SCORE_W'(1);
          end else begin
`ifdef MATCH_ROUND_TIMER_EN
            // Time-out is a draw; a hit on the same tick was handled above.
            if (cnt_zero) begin
              phase_d = PH_ROUND_END;
              cnt_d   = RE_LOAD;
            end else begin
              cnt_d = cnt_dec;
            end
`else
            cnt_d = '0;
`endif
          end
        end
        PH_CLASH: begin
          if (cnt_zero) begin
            phase_d = PH_COUNTDOWN;
            cnt_d   = CD_LOAD;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        PH_ROUND_END: begin
          if (cnt_zero) begin
            f1_d = 1'b0;
            f2_d = 1'b0;
            if ((s1_q == WIN_SCORE) || (s2_q == WIN_SCORE)) begin
              phase_d  = PH_MATCH_END;
              cnt_d    = '0;
              over_d   = 1'b1;
              winner_d = (s2_q == WIN_SCORE);
            end else begin
              phase_d = PH_COUNTDOWN;
              cnt_d   = CD_LOAD;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign round_phase         = phase_q;
  assign phase_count         = cnt_q;
  assign p1_score            = s1_q;
  assign p2_score            = s2_q;
  assign p1_attack_connected = f1_q;
  assign p2_attack_connected = f2_q;
  assign match_over          = over_q;
  assign match_winner        = winner_q;
  assign players_frozen      = (phase_q != PH_FIGHT);

endmodule

// File: tb/tb_match_round_controller.sv
// Self-checking bench for match_round_controller against a frame-level reference model.
module tb_match_round_controller;

  localparam int CD_N  = 3;
  localparam int CL_N  = 2;
  localparam int RE_N  = 2;
  localparam int RF_N  = 5;
  localparam int WIN_N = 2;
  localparam int CNT_W = 12;
  localparam int SC_W  = 2;

`ifdef MATCH_ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  localparam int P_IDLE = 0, P_CD = 1, P_FIGHT = 2, P_CLASH = 3, P_RE = 4, P_MEND = 5;

  logic             sys_clk = 1'b0;
  logic             resetn = 1'b0;
  logic             frame_clk = 1'b0;
  logic             start_btn = 1'b0;
  logic             p1_hit_raw = 1'b0;
  logic             p2_hit_raw = 1'b0;
  logic             frame_tick;
  logic             p1_attack_connected, p2_attack_connected;
  logic             players_frozen;
  logic [2:0]       round_phase;
  logic [CNT_W-1:0] phase_count;
  logic [SC_W-1:0]  p1_score, p2_score;
  logic             match_over, match_winner;

  match_round_controller #(
    .COUNTDOWN_FRAMES (CD_N),
    .CLASH_FRAMES     (CL_N),
    .ROUND_END_FRAMES (RE_N),
    .ROUND_FRAMES     (RF_N),
    .WINS_TO_MATCH    (WIN_N),
    .CNT_W            (CNT_W),
    .SCORE_W          (SC_W)
  ) dut (
    .sys_clk             (sys_clk),
    .resetn              (resetn),
    .frame_clk           (frame_clk),
    .start_btn           (start_btn),
    .p1_hit_raw          (p1_hit_raw),
    .p2_hit_raw          (p2_hit_raw),
    .frame_tick          (frame_tick),
    .p1_attack_connected (p1_attack_connected),
    .p2_attack_connected (p2_attack_connected),
    .players_frozen      (players_frozen),
    .round_phase         (round_phase),
    .phase_count         (phase_count),
    .p1_score            (p1_score),
    .p2_score            (p2_score),
    .match_over          (match_over),
    .match_winner        (match_winner)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one update per frame, straight from the round rules.
  int m_phase, m_cnt, m_s1, m_s2;
  bit m_f1, m_f2, m_over, m_win, m_pend;

  task automatic model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_s1 = 0; m_s2 = 0;
    m_f1 = 0; m_f2 = 0; m_over = 0; m_win = 0; m_pend = 0;
  endtask

  task automatic model_frame(input bit h1, input bit h2);
    case (m_phase)
      P_IDLE, P_MEND:
        if (m_pend) begin
          m_phase = P_CD; m_cnt = CD_N - 1; m_s1 = 0; m_s2 = 0; m_over = 0;
        end
      P_CD:
        if (m_cnt == 0) begin m_phase = P_FIGHT; m_cnt = TIMER ? RF_N - 1 : 0; end
        else m_cnt = m_cnt - 1;
      P_FIGHT:
        if (h1 && h2) begin
          m_phase = P_CLASH; m_cnt = CL_N - 1;
        end else if (h1 || h2) begin
          m_phase = P_RE; m_cnt = RE_N - 1;
          if (h1) begin m_f1 = 1; m_s1 = (m_s1 + 1 > WIN_N) ? WIN_N : m_s1 + 1; end
          else    begin m_f2 = 1; m_s2 = (m_s2 + 1 > WIN_N) ? WIN_N : m_s2 + 1; end
        end else if (TIMER) begin
          if (m_cnt == 0) begin m_phase = P_RE; m_cnt = RE_N - 1; end
          else m_cnt = m_cnt - 1;
        end
      P_CLASH:
        if (m_cnt == 0) begin m_phase = P_CD; m_cnt = CD_N - 1; end
        else m_cnt = m_cnt - 1;
      P_RE:
        if (m_cnt == 0) begin
          m_f1 = 0; m_f2 = 0;
          if (m_s1 == WIN_N || m_s2 == WIN_N) begin
            m_phase = P_MEND; m_cnt = 0; m_over = 1; m_win = (m_s2 == WIN_N);
          end else begin
            m_phase = P_CD; m_cnt = CD_N - 1;
          end
        end else m_cnt = m_cnt - 1;
      default: m_phase = P_IDLE;
    endcase
    m_pend = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"},  32'(round_phase), m_phase);
    chk({tag, ".count"},  32'(phase_count), m_cnt);
    chk({tag, ".s1"},     32'(p1_score), m_s1);
    chk({tag, ".s2"},     32'(p2_score), m_s2);
    chk({tag, ".f1"},     32'(p1_attack_connected), 32'(m_f1));
    chk({tag, ".f2"},     32'(p2_attack_connected), 32'(m_f2));
    chk({tag, ".over"},   32'(match_over), 32'(m_over));
    chk({tag, ".frozen"}, 32'(players_frozen), (m_phase != P_FIGHT) ? 1 : 0);
    chk({tag, ".excl"},   32'(p1_attack_connected & p2_attack_connected), 0);
    if (m_over) chk({tag, ".winner"}, 32'(match_winner), 32'(m_win));
  endtask

  // One frame: raise frame_clk, watch the strobe's timing and width, then compare state.
  task automatic do_frame(input bit h1, input bit h2, input string tag);
    int ticks = 0;
    int first = 0;
    p1_hit_raw = h1; p2_hit_raw = h2;
    @(negedge sys_clk);
    frame_clk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      if (frame_tick) begin ticks++; if (first == 0) first = i; end
    end
    frame_clk = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      @(negedge sys_clk);
      if (frame_tick) ticks++;
    end
    p1_hit_raw = 1'b0; p2_hit_raw = 1'b0;
    model_frame(h1, h2);
    chk({tag, ".tick_cnt"}, ticks, 1);
    chk({tag, ".tick_lat"}, first, 3);
    check_all(tag);
  endtask

  task automatic go(input int n, input string tag);
    for (int i = 0; i < n; i++) do_frame(1'b0, 1'b0, tag);
  endtask

  task automatic press_start();
    @(negedge sys_clk);
    start_btn = 1'b1;
    @(negedge sys_clk);
    start_btn = 1'b0;
    m_pend = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk("rst.tick", 32'(frame_tick), 0);
    chk("rst.winner", 32'(match_winner), 0);
    check_all("rst");
    resetn = 1'b1;

    // 1: start, countdown 2,1,0, then FIGHT
    press_start();
    go(3, "t1.cd");
    chk("t1.cd_end", 32'(round_phase), P_CD);
    do_frame(1'b0, 1'b0, "t1.fight");
    chk("t1.fight_phase", 32'(round_phase), P_FIGHT);
    chk("t1.unfrozen", 32'(players_frozen), 0);

    // 2: p1 scores, result held, back to countdown
    do_frame(1'b1, 1'b0, "t2.hit");
    chk("t2.f1", 32'(p1_attack_connected), 1);
    chk("t2.s1", 32'(p1_score), 1);
    go(2, "t2.re");
    chk("t2.back_cd", 32'(round_phase), P_CD);

    // 3: simultaneous hit -> clash
    go(3, "t3.cd");
    do_frame(1'b1, 1'b1, "t3.clash");
    chk("t3.clash_phase", 32'(round_phase), P_CLASH);
    go(2, "t3.hold");
    chk("t3.back_cd", 32'(round_phase), P_CD);

    // 4: p2 takes two rounds -> match end, restart clears scores
    go(3, "t4.cd");
    do_frame(1'b0, 1'b1, "t4.hit1");
    go(2, "t4.re1");
    go(3, "t4.cd2");
    do_frame(1'b0, 1'b1, "t4.hit2");
    go(2, "t4.re2");
    chk("t4.over", 32'(match_over), 1);
    chk("t4.winner", 32'(match_winner), 1);
    chk("t4.s2", 32'(p2_score), 2);
    press_start();
    do_frame(1'b0, 1'b0, "t4.restart");
    chk("t4.restart_phase", 32'(round_phase), P_CD);
    chk("t4.restart_s2", 32'(p2_score), 0);

`ifdef MATCH_ROUND_TIMER_EN
    // 5: time-out draw, then hit on the expiry tick
    go(3, "t5.cd");
    go(5, "t5.timeout");
    chk("t5.draw_phase", 32'(round_phase), P_RE);
    chk("t5.draw_s1", 32'(p1_score), 0);
    go(2, "t5.re");
    go(3, "t5.cd2");
    go(4, "t5.fight");
    do_frame(1'b1, 1'b0, "t5.expiry_hit");
    chk("t5.expiry_s1", 32'(p1_score), 1);
    go(2, "t5.re2");
`endif

    // 6: asynchronous reset in the middle of ROUND_END
    go(3, "t6.cd");
    do_frame(1'b1, 1'b0, "t6.hit");
    do_frame(1'b0, 1'b0, "t6.re");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("t6.async_tick", 32'(frame_tick), 0);
    check_all("t6.async");
    @(negedge sys_clk);
    resetn = 1'b1;
    do_frame(1'b0, 1'b0, "t6.post");

    // Randomized play
    press_start();
    for (int i = 0; i < 120; i++) begin
      bit h1, h2;
      h1 = ($urandom_range(0, 2) == 0);
      h2 = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) press_start();
      do_frame(h1, h2, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
